// File: rtl/gcd_pkg.sv
// Shared types and constants for the binary GCD engine.
// The optional go-to-done cycle counter is enabled with GCD_CYCLES_EN.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STRIP = 2'd1,
        LOOP  = 2'd2,
        FINAL = 2'd3
    } gcd_state_t;

    localparam int CYCLES_W = 16;

    // k counts common factors of two; it can never exceed WIDTH.
    function automatic int k_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/gcd_step.sv
// Combinational single iteration of the binary GCD datapath.
// term marks the end of the current phase (STRIP -> LOOP, LOOP -> FINAL).
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int KW    = 6
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [KW-1:0]    k,
    input  gcd_state_t       state,
    output logic [WIDTH-1:0] x_next,
    output logic [WIDTH-1:0] y_next,
    output logic [KW-1:0]    k_next,
    output logic             term
);

    always_comb begin
        x_next = x;
        y_next = y;
        k_next = k;
        term   = 1'b0;
        case (state)
            STRIP: begin
                if (!x[0] && !y[0]) begin
                    x_next = x >> 1;
                    y_next = y >> 1;
                    k_next = k + KW'(1);
                end else begin
                    term = 1'b1;
                end
            end
            LOOP: begin
                // Both operands are odd whenever a subtraction happens, so the
                // difference is even and the shift loses nothing.
                if (!x[0]) begin
                    x_next = x >> 1;
                end else if (!y[0]) begin
                    y_next = y >> 1;
                end else if (x == y) begin
                    term = 1'b1;
                end else if (x > y) begin
                    x_next = (x - y) >> 1;
                end else begin
                    y_next = (y - x) >> 1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/gcd_engine.sv
// Binary (Stein) GCD engine: FSM plus operand/result registers.
// Define GCD_CYCLES_EN to add the saturating go-to-done cycle counter output.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic [WIDTH-1:0]    Xi,
    input  logic [WIDTH-1:0]    Yi,
    output logic [WIDTH-1:0]    XYGCD,
    output logic                busy,
    output logic                done
`ifdef GCD_CYCLES_EN
    ,
    output logic [CYCLES_W-1:0] cycles
`endif
);

    localparam int KW = k_width(WIDTH);

    gcd_state_t       state;
    gcd_state_t       state_next;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] x_next;
    logic [WIDTH-1:0] y_next;
    logic [KW-1:0]    k_next;
    logic             term;
    logic             accept;
    logic             iterate;
    logic             finish;
    logic             both_nonzero;

    assign both_nonzero = (Xi != '0) && (Yi != '0);

    gcd_step #(
        .WIDTH(WIDTH),
        .KW   (KW)
    ) u_step (
        .x     (x),
        .y     (y),
        .k     (k),
        .state (state),
        .x_next(x_next),
        .y_next(y_next),
        .k_next(k_next),
        .term  (term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (go) state_next = both_nonzero ? STRIP : FINAL;
            STRIP: if (term) state_next = LOOP;
            LOOP:  if (term) state_next = FINAL;
            FINAL: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        accept  = (state == IDLE) && go;
        iterate = (state == STRIP) || (state == LOOP);
        finish  = (state == FINAL);
    end

    // A zero operand skips the iteration entirely: gcd(0,n) = n.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x     <= '0;
            y     <= '0;
            k     <= '0;
            XYGCD <= '0;
            done  <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                x <= both_nonzero ? Xi : (Xi | Yi);
                y <= both_nonzero ? Yi : '0;
                k <= '0;
            end else if (iterate) begin
                x <= x_next;
                y <= y_next;
                k <= k_next;
            end
            if (finish) XYGCD <= x << k;
        end
    end

`ifdef GCD_CYCLES_EN
    logic [CYCLES_W-1:0] cnt;
    logic [CYCLES_W-1:0] cnt_inc;

    assign cnt_inc = (cnt == '1) ? cnt : cnt + CYCLES_W'(1);

    // cnt includes the accepting edge; the FINAL edge adds the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            cycles <= '0;
        end else begin
            if (accept)    cnt <= CYCLES_W'(1);
            else if (busy) cnt <= cnt_inc;
            if (finish) cycles <= cnt_inc;
        end
    end
`endif

endmodule
